// File: rtl/regfile_sb_pkg.sv
// Shared types and default sizing for the scoreboarded register file.
package regfile_sb_pkg;

  localparam int unsigned XlenDefault  = 32;
  localparam int unsigned NregsDefault = 32;
  localparam int unsigned NrdDefault   = 2;

  typedef enum logic {StIdle, StClear} state_e;

  function automatic int unsigned addr_width(input int unsigned nregs);
    return $clog2(nregs);
  endfunction

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Busy-bit scoreboard: tracks reserved destinations and decides reservation acceptance.
module regfile_sb_scoreboard
  import regfile_sb_pkg::*;
#(
  parameter int unsigned NREGS = NregsDefault,
  parameter int unsigned NRD   = NrdDefault,
  localparam int unsigned AW   = addr_width(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic              wr_fire,
  input  logic [AW-1:0]     wr_addr,
  input  logic              rsv_en,
  input  logic [AW-1:0]     rsv_addr,
  input  logic              clr_active,
  input  logic [AW-1:0]     clr_addr,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD-1:0]    rd_busy,
  output logic              rsv_ok
);

  logic [NREGS-1:0] busy_q, busy_d;

  // A write landing this cycle frees the register in time for a new reservation.
  always_comb begin
    rsv_ok = rsv_en & ~clr_active & ~reset &
             (~busy_q[rsv_addr] | (wr_en & (wr_addr == rsv_addr)));
  end

  always_comb begin
    busy_d = busy_q;
    if (clr_active) begin
      busy_d[clr_addr] = 1'b0;
    end else begin
      if (wr_fire) busy_d[wr_addr] = 1'b0;
      // Applied after the write so a same-cycle reservation wins.
      if (rsv_ok && (rsv_addr != '0)) busy_d[rsv_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  for (genvar g = 0; g < NRD; g++) begin : g_rd_busy
    assign rd_busy[g] = busy_q[rd_addr[g*AW +: AW]];
  end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with busy scoreboard and sequential clear.
// Define REGFILE_SB_BYPASS_EN to forward same-cycle writeback data to the read ports.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int unsigned XLEN  = XlenDefault,
  parameter int unsigned NREGS = NregsDefault,
  parameter int unsigned NRD   = NrdDefault,
  localparam int unsigned AW   = addr_width(NREGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_addr,
  output logic                rsv_ok,
  input  logic                clr_req,
  output logic                clr_busy,
  input  logic [AW-1:0]       dbg_addr,
  output logic [XLEN-1:0]     dbg_data
);

  state_e          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] regs_q [NREGS];
  logic            clr_active;
  logic            wr_fire;
  logic [NRD-1:0]  sb_busy;

  assign clr_active = (state_q == StClear);
  assign clr_busy   = clr_active;
  assign wr_fire    = wr_en & (wr_addr != '0) & ~clr_active & ~reset;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (clr_req) begin
          state_d = StClear;
          cnt_d   = AW'(1);
        end
      end
      StClear: begin
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == AW'(NREGS - 1)) begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Register 0 is never written, so it reads as zero without extra muxing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (clr_active) begin
      regs_q[cnt_q] <= '0;
    end else if (wr_fire) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  regfile_sb_scoreboard #(
    .NREGS (NREGS),
    .NRD   (NRD)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_fire    (wr_fire),
    .wr_addr    (wr_addr),
    .rsv_en     (rsv_en),
    .rsv_addr   (rsv_addr),
    .clr_active (clr_active),
    .clr_addr   (cnt_q),
    .rd_addr    (rd_addr),
    .rd_busy    (sb_busy),
    .rsv_ok     (rsv_ok)
  );

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [AW-1:0] addr;
    assign addr = rd_addr[g*AW +: AW];

    always_comb begin
      rd_data[g*XLEN +: XLEN] = regs_q[addr];
      rd_busy[g]              = sb_busy[g];
`ifdef REGFILE_SB_BYPASS_EN
      if (wr_fire && (addr == wr_addr)) begin
        rd_data[g*XLEN +: XLEN] = wr_data;
        rd_busy[g]              = 1'b0;
      end
`endif
      if (reset) rd_data[g*XLEN +: XLEN] = '0;
    end
  end

  assign dbg_data = regs_q[dbg_addr];

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard-style bench: stimulus pushes expectations from a reference model, monitor compares.
module tb_regfile_sb;

  localparam int XL = 32;
  localparam int NR = 32;
  localparam int NP = 2;
  localparam int AW = 5;

  logic            clk = 1'b0;
  logic            reset;
  logic [AW-1:0]   rd_a0, rd_a1;
  logic [NP*AW-1:0] rd_addr;
  logic [NP*XL-1:0] rd_data;
  logic [NP-1:0]   rd_busy;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [XL-1:0]   wr_data;
  logic            rsv_en;
  logic [AW-1:0]   rsv_addr;
  logic            rsv_ok;
  logic            clr_req;
  logic            clr_busy;
  logic [AW-1:0]   dbg_addr;
  logic [XL-1:0]   dbg_data;

  assign rd_addr = {rd_a1, rd_a0};

  always #5 clk = ~clk;

  regfile_sb dut (
    .clk      (clk),
    .reset    (reset),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .rsv_ok   (rsv_ok),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  // kind: 0 rsv_ok, 1 clr_busy, 2 rd_data[idx], 3 rd_busy[idx], 4 dbg_data
  typedef struct {
    int          kind;
    int          idx;
    logic [31:0] expv;
    string       name;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  // Reference model: architectural register contents, busy flags, clear progress.
  logic [31:0] mem [NR];
  bit          bsy [NR];
  bit          clearing;
  int          cidx;

  task automatic push(input int kind, input int idx, input logic [31:0] v, input string name);
    exp_t e;
    e.kind = kind; e.idx = idx; e.expv = v; e.name = name;
    q.push_back(e);
  endtask

  function automatic logic [31:0] actual(input int kind, input int idx);
    case (kind)
      0:       return {31'b0, rsv_ok};
      1:       return {31'b0, clr_busy};
      2:       return rd_data[idx*XL +: XL];
      3:       return {31'b0, rd_busy[idx]};
      default: return dbg_data;
    endcase
  endfunction

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [31:0] got;
      e = q.pop_front();
      got = actual(e.kind, e.idx);
      n_cmp++;
      if (got !== e.expv) begin
        n_mis++;
        $display("FAIL %s[%0d]: got 0x%08h, expected 0x%08h at %0t",
                 e.name, e.idx, got, e.expv, $time);
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      mem[i] = '0;
      bsy[i] = 1'b0;
    end
    clearing = 1'b0;
    cidx = 0;
  endtask

  // Push expectations for the current inputs, advance the model, move to the next cycle.
  task automatic tick();
    bit fire, ok;
    int a;
    logic [31:0] ed;
    bit eb;
    if (reset) begin
      model_reset();
      push(0, 0, 0, "rsv_ok_rst");
      push(1, 0, 0, "clr_busy_rst");
      for (int i = 0; i < NP; i++) begin
        push(2, i, 0, "rd_data_rst");
        push(3, i, 0, "rd_busy_rst");
      end
      push(4, 0, 0, "dbg_rst");
    end else begin
      fire = wr_en && (wr_addr != 0) && !clearing;
      ok   = rsv_en && !clearing && (!bsy[rsv_addr] || (wr_en && (wr_addr == rsv_addr)));
      push(0, 0, {31'b0, ok}, "rsv_ok");
      push(1, 0, {31'b0, clearing}, "clr_busy");
      for (int i = 0; i < NP; i++) begin
        a  = (i == 0) ? int'(rd_a0) : int'(rd_a1);
        ed = mem[a];
        eb = bsy[a];
`ifdef REGFILE_SB_BYPASS_EN
        if (fire && (a == int'(wr_addr))) begin
          ed = wr_data;
          eb = 1'b0;
        end
`endif
        push(2, i, ed, "rd_data");
        push(3, i, {31'b0, eb}, "rd_busy");
      end
      push(4, 0, mem[dbg_addr], "dbg_data");
      if (clearing) begin
        mem[cidx] = '0;
        bsy[cidx] = 1'b0;
        cidx++;
        if (cidx == NR) clearing = 1'b0;
      end else begin
        if (fire) begin
          mem[wr_addr] = wr_data;
          bsy[wr_addr] = 1'b0;
        end
        if (ok && (rsv_addr != 0)) bsy[rsv_addr] = 1'b1;
        if (clr_req) begin
          clearing = 1'b1;
          cidx = 1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 0; wr_addr = 0; wr_data = 0;
    rsv_en = 0; rsv_addr = 0; clr_req = 0;
    rd_a0 = 0; rd_a1 = 0; dbg_addr = 0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
    idle(); wr_en = 1; wr_addr = a; wr_data = d;
  endtask

  initial begin
    reset = 1;
    idle();
    model_reset();
    @(posedge clk);
    #1;
    tick();
    tick();
    reset = 0;

    // Write then read back; register 0 ignores writes.
    wr(5, 32'h0000_00A5); tick();
    idle(); rd_a0 = 5; push(2, 0, 32'h0000_00A5, "x5_read"); tick();
    wr(0, 32'hFFFF_FFFF); tick();
    idle(); rd_a0 = 0; push(2, 0, 0, "x0_read"); push(3, 0, 0, "x0_busy"); tick();

    // Reservation, double reservation rejected, writeback frees.
    idle(); rsv_en = 1; rsv_addr = 7; push(0, 0, 1, "rsv7_ok"); tick();
    idle(); rd_a0 = 7; push(3, 0, 1, "x7_busy"); tick();
    idle(); rsv_en = 1; rsv_addr = 7; push(0, 0, 0, "rsv7_again"); tick();
    wr(7, 32'h0000_0777); tick();
    idle(); rd_a0 = 7; push(3, 0, 0, "x7_freed"); tick();

    // Same-cycle write and reservation of a busy register: reservation wins.
    idle(); rsv_en = 1; rsv_addr = 9; tick();
    wr(9, 32'h0000_1234); rsv_en = 1; rsv_addr = 9; push(0, 0, 1, "rsv9_wr_ok"); tick();
    idle(); rd_a0 = 9; push(2, 0, 32'h0000_1234, "x9_data"); push(3, 0, 1, "x9_busy"); tick();

    // Write/read collision on port 1.
    wr(3, 32'h0000_0011); tick();
    wr(3, 32'hDEAD_BEEF); rd_a1 = 3;
`ifdef REGFILE_SB_BYPASS_EN
    push(2, 1, 32'hDEAD_BEEF, "x3_bypass");
`else
    push(2, 1, 32'h0000_0011, "x3_nobypass");
`endif
    tick();

    // Sequential clear with writes and reservations ignored.
    wr(31, 32'h0000_0055); tick();
    idle(); rsv_en = 1; rsv_addr = 31; push(0, 0, 1, "rsv31_ok"); tick();
    idle(); clr_req = 1; push(1, 0, 0, "clr_busy_idle"); tick();
    for (int c = 0; c < NR - 1; c++) begin
      wr(1, 32'h0000_0077); rsv_en = 1; rsv_addr = 5; clr_req = 1; rd_a0 = 31;
      push(1, 0, 1, "clr_busy_on");
      push(0, 0, 0, "rsv_in_clear");
      tick();
    end
    idle(); rd_a0 = 31; rd_a1 = 1;
    push(1, 0, 0, "clr_busy_done");
    push(2, 0, 0, "x31_cleared");
    push(3, 0, 0, "x31_unbusy");
    push(2, 1, 0, "x1_wr_ignored");
    tick();

    // Reset in the middle of a clear.
    wr(10, 32'h0000_0ABC); tick();
    idle(); clr_req = 1; tick();
    for (int c = 0; c < 9; c++) begin
      idle(); tick();
    end
    idle(); reset = 1; rd_a0 = 10; push(1, 0, 0, "clr_busy_reset"); tick();
    reset = 0;
    wr(4, 32'h0000_0099); tick();
    idle(); rd_a0 = 4; rd_a1 = 10;
    push(2, 0, 32'h0000_0099, "x4_after_reset");
    push(2, 1, 0, "x10_after_reset");
    tick();
    for (int r = 0; r < NR; r++) begin
      idle(); dbg_addr = AW'(r);
      push(4, 0, (r == 4) ? 32'h0000_0099 : 32'h0, "dbg_after_reset");
      tick();
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      wr_en    = ($urandom % 2) == 0;
      wr_addr  = ($urandom % 2) ? AW'($urandom_range(0, 7)) : AW'($urandom);
      wr_data  = $urandom;
      rsv_en   = ($urandom % 2) == 0;
      rsv_addr = ($urandom % 2) ? AW'($urandom_range(0, 7)) : AW'($urandom);
      clr_req  = ($urandom % 60) == 0;
      rd_a0    = ($urandom % 3 == 0) ? wr_addr : AW'($urandom_range(0, 7));
      rd_a1    = ($urandom % 3 == 0) ? wr_addr : AW'($urandom);
      dbg_addr = AW'($urandom);
      reset    = ($urandom % 250) == 0;
      tick();
      reset = 0;
    end

    idle();
    for (int w = 0; w < 4 && q.size() > 0; w++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      n_mis++;
      $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
